// File: rtl/adder4_bist.sv
// rtl/adder4_bist.sv - closed-loop built-in self-test engine for a WIDTH-bit ripple adder
// Sweeps every {ci,a,b} vector, checks {co,s} against a reference sum, records errors and first failure.
module adder4_bist #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    output logic [WIDTH-1:0]   o_dut_a,
    output logic [WIDTH-1:0]   o_dut_b,
    output logic               o_dut_ci,
    input  logic [WIDTH-1:0]   i_dut_s,
    input  logic               i_dut_co,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_pass,
    output logic [15:0]        o_err_count,
    output logic [2*WIDTH:0]   o_first_fail
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [3:0] SETTLE_C = 4'(SETTLE);

    state_t             r_state;
    logic [2*WIDTH:0]   r_vec;
    logic [3:0]         r_cnt;
    logic [15:0]        r_err_count;
    logic [2*WIDTH:0]   r_first_fail;
    logic               r_fail_seen;
    logic               r_busy;
    logic               r_done;
    logic               r_pass;

    logic [WIDTH:0]     w_expected;
    logic               w_mismatch;
    logic               w_last;
    logic               w_launch;

    // Operand pins are the vector register itself, so they hold the last vector in DONE.
    assign o_dut_ci = r_vec[2*WIDTH];
    assign o_dut_a  = r_vec[2*WIDTH-1:WIDTH];
    assign o_dut_b  = r_vec[WIDTH-1:0];

    assign w_expected = {1'b0, o_dut_a} + {1'b0, o_dut_b} + {{WIDTH{1'b0}}, o_dut_ci};
    assign w_mismatch = ({i_dut_co, i_dut_s} != w_expected);
    assign w_last     = &r_vec;
    assign w_launch   = i_start && (r_state != S_RUN);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_vec        <= '0;
            r_cnt        <= '0;
            r_err_count  <= '0;
            r_first_fail <= '0;
            r_fail_seen  <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
        end else if (w_launch) begin
            r_state      <= S_RUN;
            r_vec        <= '0;
            r_cnt        <= '0;
            r_err_count  <= '0;
            r_first_fail <= '0;
            r_fail_seen  <= 1'b0;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (r_cnt != SETTLE_C) begin
                        r_cnt <= r_cnt + 4'd1;
                    end else begin
                        if (w_mismatch) begin
                            if (r_err_count != 16'hFFFF) begin
                                r_err_count <= r_err_count + 16'd1;
                            end
                            if (!r_fail_seen) begin
                                r_first_fail <= r_vec;
                                r_fail_seen  <= 1'b1;
                            end
                        end
                        // Terminal check precedes the increment: no wrap into a second sweep.
                        if (w_last) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_vec <= r_vec + 1'b1;
                            r_cnt <= '0;
                        end
                    end
                end
                S_DONE: begin
                    // Flags follow one edge after the final compare so pass sees the last error update.
                    r_done <= 1'b1;
                    r_pass <= (r_err_count == 16'd0);
                end
                default: begin
                    r_done <= 1'b0;
                    r_pass <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_pass       = r_pass;
    assign o_err_count  = r_err_count;
    assign o_first_fail = r_first_fail;

endmodule

// File: tb/tb_adder4_bist.sv
// tb/tb_adder4_bist.sv - directed self-checking bench for adder4_bist
// Drives two engines (SETTLE=1 and SETTLE=3) against behavioural adders with injectable faults.
module tb_adder4_bist;

    logic       clk;
    logic       reset;
    logic       start0, start3;
    logic       sel3;
    logic       fault_s0, fault_co;

    logic [3:0] a0, b0, s0, a3, b3, s3;
    logic       ci0, co0, ci3, co3;
    logic       busy0, done0, pass0, busy3, done3, pass3;
    logic [15:0] err0, err3;
    logic [8:0] ff0, ff3;
    logic [4:0] sum0, sum3;

    int errors = 0;
    int checks = 0;
    int n;
    logic       snap_busy, snap_done, snap_pass;
    logic [15:0] snap_err;
    logic [8:0] snap_ff;
    logic [8:0] snap_vec;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign sum0 = {1'b0, a0} + {1'b0, b0} + {4'b0, ci0};
    assign s0   = fault_s0 ? {sum0[3:1], 1'b0} : sum0[3:0];
    assign co0  = fault_co ? 1'b0 : sum0[4];
    assign sum3 = {1'b0, a3} + {1'b0, b3} + {4'b0, ci3};
    assign s3   = sum3[3:0];
    assign co3  = sum3[4];

    adder4_bist #(.WIDTH(4), .SETTLE(1)) u_dut (
        .i_clk(clk), .i_reset(reset), .i_start(start0),
        .o_dut_a(a0), .o_dut_b(b0), .o_dut_ci(ci0),
        .i_dut_s(s0), .i_dut_co(co0),
        .o_busy(busy0), .o_done(done0), .o_pass(pass0),
        .o_err_count(err0), .o_first_fail(ff0)
    );

    adder4_bist #(.WIDTH(4), .SETTLE(3)) u_dut3 (
        .i_clk(clk), .i_reset(reset), .i_start(start3),
        .o_dut_a(a3), .o_dut_b(b3), .o_dut_ci(ci3),
        .i_dut_s(s3), .i_dut_co(co3),
        .o_busy(busy3), .o_done(done3), .o_pass(pass3),
        .o_err_count(err3), .o_first_fail(ff3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_start(input logic v);
        if (sel3) start3 = v;
        else      start0 = v;
    endtask

    // Start edge is edge 0; n counts edges until done is seen. Snapshot taken just after edge 0.
    task automatic run_sweep(input int hold, input int repulse);
        set_start(1'b1);
        @(posedge clk); #1;
        snap_busy = sel3 ? busy3 : busy0;
        snap_done = sel3 ? done3 : done0;
        snap_pass = sel3 ? pass3 : pass0;
        snap_err  = sel3 ? err3  : err0;
        snap_ff   = sel3 ? ff3   : ff0;
        snap_vec  = sel3 ? {ci3, a3, b3} : {ci0, a0, b0};
        n = 0;
        while (!(sel3 ? done3 : done0) && n < 5000) begin
            set_start((n < hold - 1) || (repulse != 0 && n == repulse));
            @(posedge clk); #1;
            n++;
        end
        set_start(1'b0);
    endtask

    initial begin
        reset = 1'b1; start0 = 1'b0; start3 = 1'b0; sel3 = 1'b0;
        fault_s0 = 1'b0; fault_co = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        chk("rst_busy", {31'b0, busy0}, 0);
        chk("rst_done", {31'b0, done0}, 0);
        chk("rst_pass", {31'b0, pass0}, 0);
        chk("rst_err", {16'b0, err0}, 0);
        chk("rst_first", {23'b0, ff0}, 0);
        chk("rst_ops", {23'b0, ci0, a0, b0}, 0);

        // Correct adder, start held three cycles: one sweep only.
        run_sweep(3, 0);
        chk("t1_busy_after_start", {31'b0, snap_busy}, 1);
        chk("t1_vec0", {23'b0, snap_vec}, 0);
        chk("t1_latency", n, 1025);
        chk("t1_pass", {31'b0, pass0}, 1);
        chk("t1_err", {16'b0, err0}, 0);
        chk("t1_first", {23'b0, ff0}, 0);
        chk("t1_busy_end", {31'b0, busy0}, 0);

        // Sum bit 0 stuck low: every odd sum fails.
        fault_s0 = 1'b1;
        run_sweep(1, 0);
        chk("t2_latency", n, 1025);
        chk("t2_pass", {31'b0, pass0}, 0);
        chk("t2_err", {16'b0, err0}, 256);
        chk("t2_first", {23'b0, ff0}, 9'h001);
        chk("t2_hold_ops", {23'b0, ci0, a0, b0}, 9'h1FF);

        // Restart from DONE clears results; a start at cycle 100 mid-sweep is ignored.
        fault_s0 = 1'b0;
        run_sweep(1, 100);
        chk("t5_done_drop", {31'b0, snap_done}, 0);
        chk("t5_pass_drop", {31'b0, snap_pass}, 0);
        chk("t5_err_clear", {16'b0, snap_err}, 0);
        chk("t5_first_clear", {23'b0, snap_ff}, 0);
        chk("t5_busy", {31'b0, snap_busy}, 1);
        chk("t5_latency", n, 1025);
        chk("t5_pass", {31'b0, pass0}, 1);

        // Carry-out stuck low.
        fault_co = 1'b1;
        run_sweep(1, 0);
        chk("t3_err", {16'b0, err0}, 256);
        chk("t3_first", {23'b0, ff0}, 9'h01F);
        chk("t3_pass", {31'b0, pass0}, 0);
        fault_co = 1'b0;

        // Reset 300 cycles into a faulty sweep aborts with no partial results.
        fault_s0 = 1'b1;
        start0 = 1'b1;
        @(posedge clk); #1 start0 = 1'b0;
        repeat (299) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        chk("t4_busy", {31'b0, busy0}, 0);
        chk("t4_done", {31'b0, done0}, 0);
        chk("t4_err", {16'b0, err0}, 0);
        chk("t4_first", {23'b0, ff0}, 0);
        chk("t4_ops", {23'b0, ci0, a0, b0}, 0);
        fault_s0 = 1'b0;
        run_sweep(1, 0);
        chk("t4_latency", n, 1025);
        chk("t4_pass", {31'b0, pass0}, 1);

        // SETTLE=3 engine: four cycles per vector.
        sel3 = 1'b1;
        run_sweep(1, 0);
        chk("t6_latency", n, 2049);
        chk("t6_pass", {31'b0, pass3}, 1);
        chk("t6_err", {16'b0, err3}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/adder4_bist.md
Name: adder4_bist

Overview:
- Synthesizable built-in self-test engine for the 4-bit ripple adder (`adder_4bit`) used by the MIPS datapath.
- Drives the full operand space {ci, a, b} into the adder under test, reads back s/co, and compares them against an internal reference sum.
- Accumulates an error count, captures the first failing vector and reports pass/fail.
- Sits beside the adder instance; it replaces the open-loop stimulus bench with a closed-loop driver and checker usable in silicon and in simulation.

Parameters:
- WIDTH, 4, operand width of the adder under test.
- SETTLE, 1, extra clock cycles a vector is held before the result is sampled (0..15).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a sweep.
- dut_a  output  WIDTH  operand a to the adder.
- dut_b  output  WIDTH  operand b to the adder.
- dut_ci  output  1  carry-in to the adder.
- dut_s  input  WIDTH  sum returned by the adder.
- dut_co  input  1  carry-out returned by the adder.
- busy  output  1  sweep in progress.
- done  output  1  sweep complete; held until the next start or reset.
- pass  output  1  valid while done; 1 means err_count == 0.
- err_count  output  16  number of mismatching vectors, saturating.
- first_fail  output  2*WIDTH+1  {ci,a,b} of the first mismatch; 0 if none.

Behaviour:
- Reset: synchronous, active-high.
  - State returns to IDLE.
  - dut_a, dut_b, dut_ci, busy, done, pass, err_count, first_fail all become 0.
  - Internal vector index and settle counter clear.
  - Reset has priority over every other event, including a sweep in progress (abort with no partial results).
- State IDLE:
  - start=1 -> RUN. On the same edge: vec<=0, cnt<=0, err_count<=0, first_fail<=0, fail_seen<=0.
- State RUN:
  - busy=1.
  - {dut_ci, dut_a, dut_b} = vec (registered outputs; vector 0 is on the pins the cycle after start is sampled).
  - cnt<SETTLE: cnt<=cnt+1.
  - cnt==SETTLE: compare {dut_co, dut_s} with expected = dut_a + dut_b + dut_ci, computed at WIDTH+1 bits with no truncation.
  - On mismatch:
    - err_count<=err_count+1, saturating at 16'hFFFF.
    - If fail_seen==0: first_fail<=vec, fail_seen<=1.
  - If vec == all-ones (last vector): -> DONE. Otherwise vec<=vec+1, cnt<=0.
- Vector duration: each vector occupies exactly SETTLE+1 cycles.
- Sweep timing:
  - Sweep length is 2^(2*WIDTH+1) vectors.
  - done rises (SETTLE+1)*2^(2*WIDTH+1) + 1 edges after the start edge. With defaults: 512 vectors, 1025 edges.
- State DONE:
  - busy=0, done=1, pass=(err_count==0).
  - Operand outputs hold their last vector.
  - start=1 -> RUN with the same clearing as from IDLE (restart).
- Other rules:
  - start is ignored while busy.
  - start held high for several cycles in IDLE launches exactly one sweep.
  - pass is 0 whenever done=0.
  - The vector index is a (2*WIDTH+1)-bit counter.
  - There is no wrap into a second sweep: the terminal-vector check precedes the increment.

Test Plan:
1. Correct adder connected, defaults, start pulse -> busy for 1024 cycles; done=1 at edge 1025; pass=1; err_count=0; first_fail=0.
2. Fault: dut_s[0] forced 0 -> done; pass=0; err_count=256 (all odd sums); first_fail=9'h001 (ci=0, a=0, b=1).
3. Fault: dut_co forced 0 -> err_count=256 (120 vectors with ci=0 plus 136 with ci=1 where the sum is ≥16); first_fail=9'h01F (a=1, b=15, ci=0).
4. reset asserted at cycle 300 of a sweep -> next edge: busy=0, done=0, err_count=0, operands 0. A fresh start then completes normally with pass=1.
5. start re-pulsed at cycle 100 of a sweep -> ignored; done still at edge 1025. A start pulse in DONE -> done drops next edge and counts clear.
6. SETTLE=3, correct adder -> each vector held 4 cycles; done at edge 2049; pass=1.
